// File: rtl/mul_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_div_pkg                                               |
// | Brief    : Shared op codes, FSM state encoding and width constant    |
// |            for the iterative multiply/divide unit.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mul_div_pkg;

  // Operand/result width; the unit performs exactly W iterations.
  localparam int W = 16;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,  // low half of product
    OP_MULH = 2'b01,  // high half of product
    OP_DIV  = 2'b10,  // quotient
    OP_REM  = 2'b11   // remainder
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Divide-family ops share bit 1 of the op code.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_div_step                                              |
// | Brief    : One combinational iteration of shift-add multiply or      |
// |            restoring division on a 2W+1 bit accumulator.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mul_div_step #(
  parameter int W = 16
) (
  input  logic           is_div,
  input  logic [2*W:0]   acc,
  input  logic [W-1:0]   operand,
  output logic [2*W:0]   acc_next,
  output logic           bit_out
);

  // Multiply view: acc = {upper (W+1), multiplier (W)}.
  logic [W:0]   w_upper;
  logic [W:0]   w_sum;
  logic [2*W:0] w_mul_full;
  // Divide view: acc = {remainder (W+1), dividend/quotient (W)}.
  logic [2*W:0] w_shifted;
  logic [W:0]   w_rem_s;
  logic         w_ge;

  assign w_upper    = acc[2*W:W];
  assign w_sum      = acc[0] ? (w_upper + {1'b0, operand}) : w_upper;
  assign w_mul_full = {w_sum, acc[W-1:0]};

  assign w_shifted  = {acc[2*W-1:0], 1'b0};
  assign w_rem_s    = w_shifted[2*W:W];
  assign w_ge       = (w_rem_s >= {1'b0, operand});

  // Select the iteration result; the quotient bit is returned separately
  // and the low bit of the divide accumulator is left zero for the caller.
  always_comb begin
    acc_next = w_mul_full >> 1;
    bit_out  = acc[0];
    if (is_div) begin
      acc_next = {(w_ge ? (w_rem_s - {1'b0, operand}) : w_rem_s), w_shifted[W-1:0]};
      bit_out  = w_ge;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul_div_unit                                              |
// | Brief    : Iterative W-bit multiply/divide execute unit. Accepts an  |
// |            op in IDLE or DONE, iterates W cycles, spends one cycle   |
// |            forming the result, then pulses done/we for one cycle.    |
// |            Optional: MUL_DIV_SIGNED_OPS_EN enables two's-complement  |
// |            operands when signed_op=1.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int W  = mul_div_pkg::W,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          signed_op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [AW-1:0] waddr_in,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  result
);

  // Counter reaches W after the last iteration, so it needs one extra bit.
  localparam int CW = $clog2(W) + 1;

  state_e         r_state;
  state_e         w_state_next;
  logic [CW-1:0]  r_count;
  logic [2*W:0]   r_acc;
  logic [W-1:0]   r_operand;
  op_e            r_op;
  logic           r_neg_main;
  logic           r_neg_rem;
  logic [AW-1:0]  r_waddr;
  logic [W-1:0]   r_result;

  logic           w_accept;
  logic           w_last;
  logic           w_is_div;
  logic [2*W:0]   w_step_acc;
  logic           w_step_bit;
  logic [2*W:0]   w_acc_iter;
  logic           w_sa;
  logic           w_sb;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic           w_neg_main;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_final;

`ifdef MUL_DIV_SIGNED_OPS_EN
  assign w_sa = signed_op & a[W-1];
  assign w_sb = signed_op & b[W-1];
`else
  logic w_unused_signed_op;
  assign w_unused_signed_op = signed_op;
  assign w_sa = 1'b0;
  assign w_sb = 1'b0;
`endif

  // The core always works on magnitudes; signs are reapplied at the end.
  assign w_mag_a = w_sa ? -a : a;
  assign w_mag_b = w_sb ? -b : b;
  // A zero divisor keeps the all-ones quotient unsigned.
  assign w_neg_main = (w_sa ^ w_sb) & (|b);

  assign w_accept = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last   = (r_count == CW'(W));
  assign w_is_div = op_is_div(r_op);

  mul_div_step #(.W(W)) u_step (
    .is_div   (w_is_div),
    .acc      (r_acc),
    .operand  (r_operand),
    .acc_next (w_step_acc),
    .bit_out  (w_step_bit)
  );

  assign w_acc_iter = w_is_div ? {w_step_acc[2*W:1], w_step_bit} : w_step_acc;

  assign w_prod = r_neg_main ? -r_acc[2*W-1:0] : r_acc[2*W-1:0];
  assign w_quo  = r_neg_main ? -r_acc[W-1:0]   : r_acc[W-1:0];
  assign w_rem  = r_neg_rem  ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  // Pick the half or quotient/remainder requested by the latched op.
  always_comb begin
    w_final = w_prod[W-1:0];
    unique case (r_op)
      OP_MUL:  w_final = w_prod[W-1:0];
      OP_MULH: w_final = w_prod[2*W-1:W];
      OP_DIV:  w_final = w_quo;
      OP_REM:  w_final = w_rem;
      default: w_final = w_prod[W-1:0];
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, load result on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_operand  <= '0;
      r_op       <= OP_MUL;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_waddr    <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_count    <= '0;
      r_acc      <= {{(W+1){1'b0}}, w_mag_a};
      r_operand  <= w_mag_b;
      r_op       <= op_e'(op);
      r_neg_main <= w_neg_main;
      r_neg_rem  <= w_sa;
      r_waddr    <= waddr_in;
    end else if (r_state == ST_RUN) begin
      if (w_last) begin
        r_result <= w_final;
      end else begin
        r_acc   <= w_acc_iter;
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign we     = done;
  assign waddr  = r_waddr;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mul_div_unit                                           |
// | Brief    : Directed, table-driven bench for mul_div_unit plus        |
// |            hand-written busy, back-to-back and reset sequences.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic        signed_op;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  waddr_in;
  logic        busy;
  logic        done;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] result;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        sop;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  wa;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  mul_div_unit #(.W(16), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .waddr_in  (waddr_in),
    .busy      (busy),
    .done      (done),
    .we        (we),
    .waddr     (waddr),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [1:0] o, input logic s,
                     input logic [15:0] va, input logic [15:0] vb,
                     input logic [2:0] wa, input logic [15:0] exp);
    vec_t v;
    v.name = name; v.op = o; v.sop = s; v.a = va; v.b = vb; v.wa = wa; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Present an op, let edge E0 sample it, then drop start at the next negedge.
  task automatic launch(input logic [1:0] o, input logic s, input logic [15:0] va,
                        input logic [15:0] vb, input logic [2:0] wa);
    @(negedge clk);
    op = o; signed_op = s; a = va; b = vb; waddr_in = wa; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of edges until done is seen (0 on timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_we(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (we) n++;
    end
  endtask

  initial begin
    int lat;
    int nwe;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; signed_op = 1'b0;
    a = '0; b = '0; waddr_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_done",   {31'd0, done},   32'd0);
    check("reset_we",     {31'd0, we},     32'd0);
    check("reset_waddr",  {29'd0, waddr},  32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    rst_n = 1'b1;

    add("mul_lo_1234x10",   2'b00, 1'b0, 16'h1234, 16'h0010, 3'd1, 16'h2340);
    add("mul_hi_1234x10",   2'b01, 1'b0, 16'h1234, 16'h0010, 3'd2, 16'h0001);
    add("mul_lo_ffffxffff", 2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 3'd3, 16'h0001);
    add("mul_hi_ffffxffff", 2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 3'd4, 16'hFFFE);
    add("div_100_7",        2'b10, 1'b0, 16'd100,  16'd7,    3'd5, 16'h000E);
    add("rem_100_7",        2'b11, 1'b0, 16'd100,  16'd7,    3'd6, 16'h0002);
    add("div_by_zero",      2'b10, 1'b0, 16'h1234, 16'h0000, 3'd7, 16'hFFFF);
    add("rem_by_zero",      2'b11, 1'b0, 16'h1234, 16'h0000, 3'd1, 16'h1234);
`ifdef MUL_DIV_SIGNED_OPS_EN
    add("sdiv_m7_2",        2'b10, 1'b1, 16'hFFF9, 16'h0002, 3'd2, 16'hFFFD);
    add("srem_m7_2",        2'b11, 1'b1, 16'hFFF9, 16'h0002, 3'd3, 16'hFFFF);
    add("sdiv_ovf",         2'b10, 1'b1, 16'h8000, 16'hFFFF, 3'd4, 16'h8000);
    add("srem_ovf",         2'b11, 1'b1, 16'h8000, 16'hFFFF, 3'd5, 16'h0000);
    add("smul_lo_m3x5",     2'b00, 1'b1, 16'hFFFD, 16'h0005, 3'd6, 16'hFFF1);
    add("smul_hi_m3x5",     2'b01, 1'b1, 16'hFFFD, 16'h0005, 3'd7, 16'hFFFF);
    add("sdiv_m7_0",        2'b10, 1'b1, 16'hFFF9, 16'h0000, 3'd1, 16'hFFFF);
    add("srem_m7_0",        2'b11, 1'b1, 16'hFFF9, 16'h0000, 3'd2, 16'hFFF9);
`else
    // signed_op has no effect: plain unsigned 0xFFF9 / 2.
    add("udiv_sop_ignored", 2'b10, 1'b1, 16'hFFF9, 16'h0002, 3'd2, 16'h7FFC);
    add("urem_sop_ignored", 2'b11, 1'b1, 16'hFFF9, 16'h0002, 3'd3, 16'h0001);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i].op, vecs[i].sop, vecs[i].a, vecs[i].b, vecs[i].wa);
      check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(lat);
      check({vecs[i].name, "_latency"}, lat, 32'd17);
      check({vecs[i].name, "_result"}, {16'd0, result}, {16'd0, vecs[i].exp});
      check({vecs[i].name, "_we"}, {31'd0, we}, 32'd1);
      check({vecs[i].name, "_waddr"}, {29'd0, waddr}, {29'd0, vecs[i].wa});
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_result_hold"}, {16'd0, result}, {16'd0, vecs[i].exp});
    end

    // start while busy is ignored and not queued.
    launch(2'b00, 1'b0, 16'h1234, 16'h0010, 3'd5);
    repeat (4) @(negedge clk);
    op = 2'b10; a = 16'd100; b = 16'd7; waddr_in = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("busy_ign_latency", lat, 32'd12);
    check("busy_ign_result", {16'd0, result}, 32'h2340);
    check("busy_ign_waddr", {29'd0, waddr}, 32'd5);
    count_we(25, nwe);
    check("busy_ign_no_queue", nwe, 32'd0);

    // start held high through DONE: second op accepted back-to-back.
    @(negedge clk);
    op = 2'b10; signed_op = 1'b0; a = 16'd100; b = 16'd7; waddr_in = 3'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'b11; a = 16'h1234; b = 16'h0000; waddr_in = 3'd6;
    wait_done(lat);
    check("b2b_first_latency", lat, 32'd17);
    check("b2b_first_result", {16'd0, result}, 32'h000E);
    check("b2b_first_waddr", {29'd0, waddr}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_second_latency", lat, 32'd17);
    check("b2b_second_result", {16'd0, result}, 32'h1234);
    check("b2b_second_waddr", {29'd0, waddr}, 32'd6);

    // Reset in the middle of an operation aborts it.
    launch(2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 3'd4);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy",   {31'd0, busy},   32'd0);
    check("rst_mid_done",   {31'd0, done},   32'd0);
    check("rst_mid_we",     {31'd0, we},     32'd0);
    check("rst_mid_result", {16'd0, result}, 32'd0);
    check("rst_mid_waddr",  {29'd0, waddr},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_we(25, nwe);
    check("rst_mid_no_write", nwe, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
